// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - shared decode-stage encodings, field positions and immediate extension
package decode_stage_pkg;

    localparam int DATA_W   = 32;
    localparam int RF_DEPTH = 32;
    localparam int RF_AW    = 5;

    typedef enum logic [1:0] {
        IMM_ZE     = 2'b00,
        IMM_SE     = 2'b01,
        IMM_LUI    = 2'b10,
        IMM_SE_SL2 = 2'b11
    } imm_ext_e;

    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 26;
    localparam int RS_MSB   = 25;
    localparam int RS_LSB   = 21;
    localparam int RT_MSB   = 20;
    localparam int RT_LSB   = 16;
    localparam int RD_MSB   = 15;
    localparam int RD_LSB   = 11;
    localparam int FUNC_MSB = 5;
    localparam int FUNC_LSB = 0;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;

    function automatic logic [DATA_W-1:0] extend_imm(input logic [15:0] imm, input imm_ext_e mode);
        logic [DATA_W-1:0] result;
        result = '0;
        case (mode)
            IMM_ZE:     result = {16'h0, imm};
            IMM_SE:     result = {{16{imm[15]}}, imm};
            IMM_LUI:    result = {imm, 16'h0};
            IMM_SE_SL2: result = {{14{imm[15]}}, imm, 2'b00};
            default:    result = '0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// rtl/decode_stage_register_file.sv - 2 async-read / 1 sync-write register file, R0 hardwired zero
module register_file
    import decode_stage_pkg::*;
#(
    parameter int DW    = DATA_W,
    parameter int DEPTH = RF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RF_AW-1:0] rd_addr_a,
    input  logic [RF_AW-1:0] rd_addr_b,
    output logic [DW-1:0]    rd_data_a,
    output logic [DW-1:0]    rd_data_b,
    input  logic             wr_en,
    input  logic [RF_AW-1:0] wr_addr,
    input  logic [DW-1:0]    wr_data
);

    logic [DW-1:0] regs [0:DEPTH-1];

    // Entry 0 is cleared by reset and never written; reads of it are forced to zero anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction register, operand read with write-first bypass, immediate extension
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int DATA_W   = decode_stage_pkg::DATA_W,
    parameter int RF_DEPTH = decode_stage_pkg::RF_DEPTH
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [31:0]       Instr,
    input  logic              IR_LdEn,
    input  logic              RF_B_sel,
    input  logic [1:0]        ImmExt,
    input  logic              RF_WrEn,
    input  logic [RF_AW-1:0]  RF_WrAddr,
    input  logic [DATA_W-1:0] RF_WrData,
    output logic [5:0]        Opcode,
    output logic [5:0]        Func,
    output logic [DATA_W-1:0] RF_A,
    output logic [DATA_W-1:0] RF_B,
    output logic [DATA_W-1:0] Immed
);

    logic [31:0]       ir;
    logic [RF_AW-1:0]  addr_a;
    logic [RF_AW-1:0]  addr_b;
    logic [DATA_W-1:0] rf_data_a;
    logic [DATA_W-1:0] rf_data_b;
    logic [DATA_W-1:0] next_a;
    logic [DATA_W-1:0] next_b;
    logic [DATA_W-1:0] next_imm;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ir <= '0;
        end else if (IR_LdEn) begin
            ir <= Instr;
        end
    end

    assign Opcode = ir[OPC_MSB:OPC_LSB];
    assign Func   = ir[FUNC_MSB:FUNC_LSB];
    assign addr_a = ir[RS_MSB:RS_LSB];
    assign addr_b = RF_B_sel ? ir[RT_MSB:RT_LSB] : ir[RD_MSB:RD_LSB];

    register_file #(
        .DW    (DATA_W),
        .DEPTH (RF_DEPTH)
    ) u_register_file (
        .clk       (Clk),
        .rst_n     (Reset),
        .rd_addr_a (addr_a),
        .rd_addr_b (addr_b),
        .rd_data_a (rf_data_a),
        .rd_data_b (rf_data_b),
        .wr_en     (RF_WrEn),
        .wr_addr   (RF_WrAddr),
        .wr_data   (RF_WrData)
    );

    // Write-first bypass; a zero read address wins over any pending write so R0 stays zero.
    always_comb begin
        next_a = rf_data_a;
        next_b = rf_data_b;
        if (addr_a == '0) begin
            next_a = '0;
        end else if (RF_WrEn && (RF_WrAddr == addr_a)) begin
            next_a = RF_WrData;
        end
        if (addr_b == '0) begin
            next_b = '0;
        end else if (RF_WrEn && (RF_WrAddr == addr_b)) begin
            next_b = RF_WrData;
        end
    end

    always_comb begin
        next_imm = extend_imm(ir[IMM_MSB:IMM_LSB], imm_ext_e'(ImmExt));
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            RF_A  <= '0;
            RF_B  <= '0;
            Immed <= '0;
        end else begin
            RF_A  <= next_a;
            RF_B  <= next_b;
            Immed <= next_imm;
        end
    end

endmodule
